// File: rtl/gate_pkg.sv
// Shared types for the sequential multi-channel gate evaluator.
//   gate_mode_e  : 3-bit per-channel gate function select
//   eval_state_e : evaluator FSM states
package gate_pkg;

  typedef enum logic [2:0] {
    MODE_AND    = 3'd0,
    MODE_NAND   = 3'd1,
    MODE_OR     = 3'd2,
    MODE_NOR    = 3'd3,
    MODE_XOR    = 3'd4,  // odd parity
    MODE_XNOR   = 3'd5,
    MODE_ONEHOT = 3'd6,  // exactly one input high
    MODE_HOLD   = 3'd7   // keep previous result
  } gate_mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    DONE = 2'd2
  } eval_state_e;

endpackage

// File: rtl/gate_reduce.sv
// Combinational single-gate evaluator, time-shared across all channels.
//   in   : INPUT_COUNT gate inputs of the channel being evaluated
//   mode : gate function of that channel
//   prev : channel's current result (returned unchanged for HOLD)
//   y    : new result
module gate_reduce
  import gate_pkg::*;
#(
  parameter int INPUT_COUNT = 2
) (
  input  logic [INPUT_COUNT-1:0] in,
  input  gate_mode_e             mode,
  input  logic                   prev,
  output logic                   y
);

  always_comb begin
    // NOTE: y gets a value before the case so no path leaves it unassigned,
    // which would otherwise infer a latch.
    y = 1'b0;
    case (mode)
      MODE_AND:    y = &in;
      MODE_NAND:   y = ~&in;
      MODE_OR:     y = |in;
      MODE_NOR:    y = ~|in;
      MODE_XOR:    y = ^in;
      MODE_XNOR:   y = ~^in;
      MODE_ONEHOT: y = ($countones(in) == 1);
      MODE_HOLD:   y = prev;
      default:     y = 1'b0;
    endcase
  end

endmodule

// File: rtl/gate_multi_multi_seq_eval.sv
// CHANNEL_COUNT independent gates with runtime-selectable functions, evaluated
// one channel per cycle by a single shared gate_reduce after a start strobe.
//   clk         : rising-edge clock
//   logic_reset : asynchronous active-low reset
//   start       : 1-cycle evaluate request, honoured only while idle
//   mode        : per-channel function, channel c = mode[3c +: 3]
//   in          : per-channel inputs, channel c = in[c*INPUT_COUNT +: INPUT_COUNT]
//   out         : per-channel result replicated OUTPUT_COUNT times
//   toggle      : channels whose result changed in the last pass (valid with done)
//   busy        : high while a pass is in progress (EVAL and DONE)
//   done        : 1-cycle pulse ending each completed pass
module gate_multi_multi_seq_eval
  import gate_pkg::*;
#(
  parameter int INPUT_COUNT   = 2,
  parameter int OUTPUT_COUNT  = 2,
  parameter int CHANNEL_COUNT = 4
) (
  input  logic                                  clk,
  input  logic                                  logic_reset,
  input  logic                                  start,
  input  logic [3*CHANNEL_COUNT-1:0]            mode,
  input  logic [INPUT_COUNT*CHANNEL_COUNT-1:0]  in,
  output logic [OUTPUT_COUNT*CHANNEL_COUNT-1:0] out,
  output logic [CHANNEL_COUNT-1:0]              toggle,
  output logic                                  busy,
  output logic                                  done
);

  localparam int IDX_W = (CHANNEL_COUNT > 1) ? $clog2(CHANNEL_COUNT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHANNEL_COUNT - 1);

  eval_state_e              state;
  logic [IDX_W-1:0]         idx;
  logic [INPUT_COUNT-1:0]   in_q   [CHANNEL_COUNT];
  gate_mode_e               mode_q [CHANNEL_COUNT];
  logic [CHANNEL_COUNT-1:0] result;
  logic [CHANNEL_COUNT-1:0] chg;
  logic [CHANNEL_COUNT-1:0] chg_next;
  logic                     y;

  gate_reduce #(
    .INPUT_COUNT(INPUT_COUNT)
  ) u_reduce (
    .in  (in_q[idx]),
    .mode(mode_q[idx]),
    .prev(result[idx]),
    .y   (y)
  );

  // Change mask including the channel being evaluated this cycle, so the
  // mask published with done already covers the last channel.
  always_comb begin
    chg_next      = chg;
    chg_next[idx] = (y != result[idx]);
  end

  always_ff @(posedge clk or negedge logic_reset) begin
    if (!logic_reset) begin
      state  <= IDLE;
      idx    <= '0;
      result <= '0;
      chg    <= '0;
      toggle <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      // NOTE: the snapshot arrays are small registers, not RAM, so clearing
      // them in reset is cheap and keeps the shared evaluator free of X.
      for (int c = 0; c < CHANNEL_COUNT; c++) begin
        in_q[c]   <= '0;
        mode_q[c] <= MODE_AND;
      end
    end else begin
      // NOTE: all state here uses <= so every register samples the values
      // from before this edge, independent of statement order.
      case (state)
        IDLE: begin
          if (start) begin
            for (int c = 0; c < CHANNEL_COUNT; c++) begin
              in_q[c]   <= in[c*INPUT_COUNT +: INPUT_COUNT];
              mode_q[c] <= gate_mode_e'(mode[3*c +: 3]);
            end
            chg   <= '0;
            idx   <= '0;
            busy  <= 1'b1;
            state <= EVAL;
          end
        end
        EVAL: begin
          result[idx] <= y;
          chg         <= chg_next;
          if (idx == LAST_IDX) begin
            done   <= 1'b1;
            toggle <= chg_next;
            state  <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          done   <= 1'b0;
          toggle <= '0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar c = 0; c < CHANNEL_COUNT; c++) begin : g_out
    assign out[c*OUTPUT_COUNT +: OUTPUT_COUNT] = {OUTPUT_COUNT{result[c]}};
  end

endmodule

// File: tb/tb_gate_multi_multi_seq_eval.sv
// Directed self-checking bench for gate_multi_multi_seq_eval with
// CHANNEL_COUNT=4, INPUT_COUNT=2, OUTPUT_COUNT=2. Inputs change and outputs
// are sampled on the falling clock edge.
module tb_gate_multi_multi_seq_eval;

  logic        clk;
  logic        logic_reset;
  logic        start;
  logic [11:0] mode_v;
  logic [7:0]  in_v;
  logic [7:0]  out;
  logic [3:0]  toggle;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;

  gate_multi_multi_seq_eval #(
    .INPUT_COUNT  (2),
    .OUTPUT_COUNT (2),
    .CHANNEL_COUNT(4)
  ) dut (
    .clk        (clk),
    .logic_reset(logic_reset),
    .start      (start),
    .mode       (mode_v),
    .in         (in_v),
    .out        (out),
    .toggle     (toggle),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse reset mid-cycle, then release at the next falling edge.
  task automatic apply_reset();
    @(negedge clk);
    #2 logic_reset = 1'b0;
    #1;
    @(negedge clk);
    logic_reset = 1'b1;
  endtask

  // Called at a falling edge while idle. Pulses start, then checks busy,
  // done and toggle for cycles T+1..T+5 and the out value afterwards.
  // disturb: 0 none, 1 change in/mode and re-pulse start at T+2,
  //          2 assert reset mid-cycle at T+2 (aborted pass).
  task automatic run_pass(input string name, input logic [3:0] exp_tog,
                          input logic [7:0] exp_out, input int disturb);
    int  done_cnt;
    bit  aborted;
    logic       exp_busy, exp_done;
    logic [3:0] exp_tg;
    done_cnt = 0;
    aborted  = 1'b0;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL %s idle_before_start: busy=%b expected 0", name, busy);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 1; cyc <= 5; cyc++) begin
      if (disturb == 1 && cyc == 2) begin
        start  = 1'b1;
        in_v   = 8'hFF;
        mode_v = {4{3'd0}};
      end
      if (disturb == 1 && cyc == 3) start = 1'b0;
      if (disturb == 2 && cyc == 2) begin
        #2 logic_reset = 1'b0;
        #1;
        aborted = 1'b1;
        total++;
        if (out !== 8'h00 || toggle !== 4'h0 || busy !== 1'b0 || done !== 1'b0) begin
          bad++;
          $display("FAIL %s reset_immediate: out=%h toggle=%b busy=%b done=%b expected all 0",
                   name, out, toggle, busy, done);
        end
      end
      if (disturb == 2 && cyc == 3) logic_reset = 1'b1;
      exp_busy = !aborted;
      exp_done = !aborted && (cyc == 5);
      exp_tg   = exp_done ? exp_tog : 4'h0;
      if (done === 1'b1) done_cnt++;
      total++;
      if (busy !== exp_busy || done !== exp_done || toggle !== exp_tg) begin
        bad++;
        $display("FAIL %s cycle T+%0d: busy=%b done=%b toggle=%b expected busy=%b done=%b toggle=%b",
                 name, cyc, busy, done, toggle, exp_busy, exp_done, exp_tg);
      end
      @(negedge clk);
    end
    total++;
    if (done_cnt != (aborted ? 0 : 1)) begin
      bad++;
      $display("FAIL %s done_count: got %0d expected %0d", name, done_cnt, aborted ? 0 : 1);
    end
    total++;
    if (out !== exp_out) begin
      bad++;
      $display("FAIL %s out: got %h expected %h", name, out, exp_out);
    end
  endtask

  // Confirms the block stays idle (no stray pass) for n cycles.
  task automatic watch_idle(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      total++;
      if (busy !== 1'b0 || done !== 1'b0 || toggle !== 4'h0) begin
        bad++;
        $display("FAIL %s idle cycle %0d: busy=%b done=%b toggle=%b expected 0",
                 name, i, busy, done, toggle);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    logic_reset = 1'b0;
    #3;
    total++;
    if (out !== 8'h00 || toggle !== 4'h0 || busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL reset: out=%h toggle=%b busy=%b done=%b expected all 0",
               out, toggle, busy, done);
    end
    @(negedge clk);
    logic_reset = 1'b1;
  endtask

  task automatic test_xnor_all();
    mode_v = {4{3'd5}};
    in_v   = 8'h00;
    run_pass("xnor_first", 4'b1111, 8'hFF, 0);
  endtask

  task automatic test_repeat_no_change();
    run_pass("xnor_repeat", 4'b0000, 8'hFF, 0);
  endtask

  task automatic test_mixed_modes();
    apply_reset();
    // ch3..ch0: HOLD, XOR, NOR, AND with inputs 11, 01, 00, 11
    mode_v = {3'd7, 3'd4, 3'd3, 3'd0};
    in_v   = 8'b11_01_00_11;
    run_pass("mixed", 4'b0111, 8'h3F, 0);
  endtask

  task automatic test_start_while_busy();
    // Snapshot: all OR on zero inputs -> 0000, changing ch0..ch2.
    mode_v = {4{3'd2}};
    in_v   = 8'h00;
    run_pass("busy_restart", 4'b0111, 8'h00, 1);
    watch_idle("busy_restart", 6);
  endtask

  task automatic test_abort();
    mode_v = {4{3'd2}};
    in_v   = 8'hFF;
    run_pass("abort", 4'b0000, 8'h00, 2);
    watch_idle("abort", 2);
    // ONEHOT on ch3..ch0 inputs 00, 11, 10, 01 -> 0011 from cleared results.
    mode_v = {4{3'd6}};
    in_v   = 8'b00_11_10_01;
    run_pass("after_abort", 4'b0011, 8'h0F, 0);
  endtask

  task automatic test_back_to_back();
    // ch3..ch0: HOLD, NAND, XNOR, OR on 11, 10, 11, 00; previous result 0011.
    mode_v = {3'd7, 3'd1, 3'd5, 3'd2};
    in_v   = 8'b11_10_11_00;
    run_pass("nand_mix", 4'b0101, 8'h3C, 0);
    // Started on the first idle cycle after done; all HOLD changes nothing.
    mode_v = {4{3'd7}};
    in_v   = 8'h5A;
    run_pass("hold_b2b", 4'b0000, 8'h3C, 0);
  endtask

  initial begin
    start       = 1'b0;
    mode_v      = '0;
    in_v        = '0;
    logic_reset = 1'b1;
    test_reset();
    test_xnor_all();
    test_repeat_no_change();
    test_mixed_modes();
    test_start_while_busy();
    test_abort();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
